// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART receive packet parser.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHK,
    DRAIN
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_BAD_LEN = 3'd1;
  localparam logic [2:0] ERR_LINE    = 3'd2;
  localparam logic [2:0] ERR_CHK     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  // FIFO word layout {BE,OE,PE,FE,data[7:0]}: flag field is bits 11..8.
  localparam int FLAG_LSB = 8;
  localparam int FLAG_MSB = 11;

  function automatic logic has_line_err(input logic [11:0] word);
    return |word[FLAG_MSB:FLAG_LSB];
  endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload register file: one synchronous write port, one combinational read port.
module uart_pkt_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_pkt_parser.sv
// Frames UART FIFO bytes into SOF/LEN/payload/CHK packets and releases
// checksum-verified payloads on a valid/ready byte stream.
module uart_rx_pkt_parser
  import uart_pkt_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE    = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 1000
) (
  input  logic        UART_clk,
  input  logic        rst,
  input  logic [11:0] fifo_rd_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        pkt_ok,
  output logic        pkt_err,
  output logic [2:0]  err_code,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt
);

  localparam int IW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t          state, state_n;
  logic            rd_pending;
  logic [IW-1:0]   len_m1, len_m1_n;
  logic [IW-1:0]   idx, idx_n;
  logic [IW-1:0]   rd_idx, rd_idx_n;
  logic [7:0]      chk_acc, chk_n;
  logic [TW-1:0]   tmo_cnt, tmo_n;
  logic            ok_set, abort, buf_we;
  logic [2:0]      abort_code;
  logic [7:0]      rx_byte, buf_rdata;
  logic            line_err, in_pkt, tmo_hit;

  assign rx_byte  = fifo_rd_data[7:0];
  assign line_err = has_line_err(fifo_rd_data);
  assign in_pkt   = (state == LEN) || (state == PAYLOAD) || (state == CHK);
  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT_CYC));

  // One read in flight at most; no pops while draining or during a status pulse.
  assign fifo_rd_en = !fifo_empty && !rd_pending && (state != DRAIN) && !pkt_ok && !pkt_err;

  // A byte transfers on out_valid && out_ready; data and last hold while stalled.
  assign out_valid = (state == DRAIN) && !pkt_ok;
  assign out_last  = out_valid && (rd_idx == len_m1);
  assign out_data  = out_valid ? buf_rdata : 8'h00;

  uart_pkt_buf #(.DEPTH(MAX_LEN), .AW(IW)) u_buf (
    .clk   (UART_clk),
    .we    (buf_we),
    .waddr (idx),
    .wdata (rx_byte),
    .raddr (rd_idx),
    .rdata (buf_rdata)
  );

  always_comb begin
    state_n    = state;
    len_m1_n   = len_m1;
    idx_n      = idx;
    rd_idx_n   = rd_idx;
    chk_n      = chk_acc;
    tmo_n      = '0;
    buf_we     = 1'b0;
    ok_set     = 1'b0;
    abort      = 1'b0;
    abort_code = ERR_NONE;

    // An arriving word always beats expiry, so the timer only acts on idle cycles.
    if (in_pkt && !rd_pending) begin
      if (tmo_hit) begin
        abort      = 1'b1;
        abort_code = ERR_TIMEOUT;
      end else begin
        tmo_n = tmo_cnt + TW'(1);
      end
    end

    case (state)
      HUNT: begin
        if (rd_pending && !line_err && (rx_byte == SOF_BYTE)) state_n = LEN;
      end
      LEN: begin
        if (rd_pending) begin
          if (line_err) begin
            abort      = 1'b1;
            abort_code = ERR_LINE;
          end else if ((rx_byte != 8'd0) && (rx_byte <= 8'(MAX_LEN))) begin
            len_m1_n = IW'(rx_byte - 8'd1);
            chk_n    = rx_byte;
            idx_n    = '0;
            state_n  = PAYLOAD;
          end else begin
            abort      = 1'b1;
            abort_code = ERR_BAD_LEN;
          end
        end
      end
      PAYLOAD: begin
        if (rd_pending) begin
          if (line_err) begin
            abort      = 1'b1;
            abort_code = ERR_LINE;
          end else begin
            buf_we = 1'b1;
            chk_n  = chk_acc ^ rx_byte;
            idx_n  = idx + IW'(1);
            if (idx == len_m1) state_n = CHK;
          end
        end
      end
      CHK: begin
        if (rd_pending) begin
          if (line_err) begin
            abort      = 1'b1;
            abort_code = ERR_LINE;
          end else if (rx_byte == chk_acc) begin
            ok_set   = 1'b1;
            rd_idx_n = '0;
            state_n  = DRAIN;
          end else begin
            abort      = 1'b1;
            abort_code = ERR_CHK;
          end
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          if (out_last) state_n = HUNT;
          else          rd_idx_n = rd_idx + IW'(1);
        end
      end
      default: state_n = HUNT;
    endcase

    if (abort) state_n = HUNT;
  end

  always_ff @(posedge UART_clk) begin
    if (rst) begin
      state      <= HUNT;
      rd_pending <= 1'b0;
      len_m1     <= '0;
      idx        <= '0;
      rd_idx     <= '0;
      chk_acc    <= '0;
      tmo_cnt    <= '0;
      pkt_ok     <= 1'b0;
      pkt_err    <= 1'b0;
      err_code   <= ERR_NONE;
      ok_cnt     <= '0;
      err_cnt    <= '0;
    end else begin
      state      <= state_n;
      rd_pending <= fifo_rd_en;
      len_m1     <= len_m1_n;
      idx        <= idx_n;
      rd_idx     <= rd_idx_n;
      chk_acc    <= chk_n;
      tmo_cnt    <= tmo_n;
      pkt_ok     <= ok_set;
      pkt_err    <= abort;
      if (abort) err_code <= abort_code;
      if (ok_set && (ok_cnt != 16'hFFFF)) ok_cnt <= ok_cnt + 16'd1;
      if (abort && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_rx_pkt_parser.sv
// Randomized bench for uart_rx_pkt_parser with a packet-level reference model
// and an ordered scoreboard of expected status pulses and output bytes.
module tb_uart_rx_pkt_parser;

  localparam logic [7:0] SOF  = 8'hA5;
  localparam int         MAXL = 16;
  localparam int         TMO  = 1000;

  logic        UART_clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] fifo_rd_data = 12'h000;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        pkt_ok, pkt_err;
  logic [2:0]  err_code;
  logic [15:0] ok_cnt, err_cnt;

  uart_rx_pkt_parser #(.SOF_BYTE(SOF), .MAX_LEN(MAXL), .TIMEOUT_CYC(TMO)) dut (
    .UART_clk     (UART_clk),
    .rst          (rst),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .pkt_ok       (pkt_ok),
    .pkt_err      (pkt_err),
    .err_code     (err_code),
    .ok_cnt       (ok_cnt),
    .err_cnt      (err_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 UART_clk = ~UART_clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  // Event encoding: {3'd1,9'd0}=pkt_ok, {3'd2,6'd0,code}=pkt_err, {3'd3,last,data}=byte
  logic [11:0] exp_q[$];
  logic [11:0] fifo_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0, last_deliv = 0, idle = 0, nbytes = 0, stall_left = 0, gap_max = 0;
  bit rd_last = 1'b0, rand_ready = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic prev_last = 1'b0;

  // reference model
  bit m_active = 1'b0;
  logic [7:0] m_pkt[$];
  int m_ok = 0, m_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic take_event(input logic [11:0] got, input string tag);
    logic [11:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
    check(tag, 32'(got), 32'(e));
  endtask

  task automatic exp_err(input int code);
    exp_q.push_back({3'd2, 6'd0, 3'(code)});
    m_err++;
    m_active = 1'b0;
  endtask

  // Packet rules applied to the bytes collected after SOF: [LEN, payload..., CHK].
  task automatic model_word(input logic [11:0] w);
    logic [7:0] b, x;
    b = w[7:0];
    if (!m_active) begin
      if (w[11:8] == 4'h0 && b == SOF) begin
        m_active = 1'b1;
        m_pkt.delete();
      end
    end else if (w[11:8] != 4'h0) begin
      exp_err(2);
    end else begin
      m_pkt.push_back(b);
      if (m_pkt.size() == 1) begin
        if (b == 8'd0 || b > MAXL) exp_err(1);
      end else if (m_pkt.size() == int'(m_pkt[0]) + 2) begin
        x = 8'h00;
        for (int i = 0; i < m_pkt.size() - 1; i++) x ^= m_pkt[i];
        if (x == b) begin
          exp_q.push_back({3'd1, 9'd0});
          m_ok++;
          for (int i = 1; i <= int'(m_pkt[0]); i++)
            exp_q.push_back({3'd3, (i == int'(m_pkt[0])), m_pkt[i]});
          m_active = 1'b0;
        end else begin
          exp_err(3);
        end
      end
    end
  endtask

  // ---------------- per-cycle driver and monitor ----------------
  task automatic cycle();
    @(negedge UART_clk);
    cyc++;
    if (pkt_ok)  take_event({3'd1, 9'd0}, "pkt_ok");
    if (pkt_err) take_event({3'd2, 6'd0, err_code}, "pkt_err");
    if (prev_stall) begin
      check("hold_valid", 32'(out_valid), 1);
      check("hold_data", 32'(out_data), 32'(prev_data));
      check("hold_last", 32'(out_last), 32'(prev_last));
    end
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (out_valid && out_ready) begin
      take_event({3'd3, out_last, out_data}, "out_byte");
      nbytes++;
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;

    if (rd_last) begin
      check("rd_when_empty", 32'(fifo_q.size() != 0), 1);
      if (fifo_q.size() != 0) begin
        fifo_rd_data = fifo_q.pop_front();
        model_word(fifo_rd_data);
      end
      idle = 0;
      last_deliv = cyc;
    end else begin
      idle++;
      if (m_active && idle == TMO + 1) exp_err(4);
    end
    fifo_empty = (fifo_q.size() == 0);
    #1;
    rd_last = fifo_rd_en;
    if (out_valid) check("rd_en_drain", 32'(fifo_rd_en), 0);
  endtask

  task automatic push(input logic [11:0] w);
    repeat ($urandom_range(0, gap_max)) cycle();
    fifo_q.push_back(w);
  endtask

  task automatic send_pkt(input int len, input bit corrupt);
    logic [7:0] x, b;
    x = 8'(len);
    push({4'h0, SOF});
    push({4'h0, 8'(len)});
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      x ^= b;
      push({4'h0, b});
    end
    push({4'h0, corrupt ? ~x : x});
  endtask

  task automatic run_idle(input string tag);
    int n = 0;
    while ((fifo_q.size() > 0 || rd_last || exp_q.size() > 0 || m_active || out_valid) && n < 4000) begin
      cycle();
      n++;
    end
    check({tag, "_settle"}, 32'(n < 4000), 1);
    repeat (3) cycle();
  endtask

  task automatic wait_delivered();
    int n = 0;
    while ((fifo_q.size() > 0 || rd_last) && n < 200) begin
      cycle();
      n++;
    end
    check("deliver_wait", 32'(n < 200), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kind, len, k, start;
    logic [11:0] w;

    rst = 1'b1;
    repeat (3) cycle();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_pkt_ok", 32'(pkt_ok), 0);
    check("rst_pkt_err", 32'(pkt_err), 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_ok_cnt", 32'(ok_cnt), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_rd_en", 32'(fifo_rd_en), 0);
    rst = 1'b0;
    cycle();

    // basic good packet
    push(12'h0A5); push(12'h002); push(12'h011); push(12'h022); push(12'h031);
    run_idle("t1");
    check("t1_ok_cnt", 32'(ok_cnt), 1);

    // checksum failure, then a good packet
    push(12'h0A5); push(12'h002); push(12'h011); push(12'h022); push(12'h030);
    send_pkt(3, 1'b0);
    run_idle("t2");
    check("t2_err_cnt", 32'(err_cnt), 1);
    check("t2_ok_cnt", 32'(ok_cnt), 2);

    // illegal lengths; an SOF in LEN is a bad length and is not re-used as SOF
    push(12'h0A5); push(12'h000);
    push(12'h0A5); push(12'h011);
    push(12'h0A5); push(12'h0A5);
    send_pkt(1, 1'b0);
    send_pkt(MAXL, 1'b0);
    run_idle("t3");
    check("t3_err_code", 32'(err_code), 1);
    check("t3_err_cnt", 32'(err_cnt), 32'(m_err));

    // line error mid-packet, then flagged words in HUNT are ignored
    push(12'h0A5); push(12'h001); push(12'h244);
    push(12'h8A5); push(12'h412);
    send_pkt(2, 1'b0);
    run_idle("t4");
    check("t4_err_code_hold", 32'(err_code), 2);
    check("t4_err_cnt", 32'(err_cnt), 32'(m_err));

    // inter-byte timeout
    push(12'h0A5); push(12'h003); push(12'h0AA);
    run_idle("t5");
    check("t5_err_code", 32'(err_code), 4);
    check("t5_err_cnt", 32'(err_cnt), 32'(m_err));

    // next byte arrives exactly on the expiry cycle: packet survives
    push(12'h0A5); push(12'h003); push(12'h0AA);
    wait_delivered();
    while (cyc < last_deliv + TMO - 1) cycle();
    fifo_q.push_back(12'h0BB);
    fifo_q.push_back(12'h0CC);
    fifo_q.push_back({4'h0, 8'h03 ^ 8'hAA ^ 8'hBB ^ 8'hCC});
    run_idle("t5b");
    check("t5b_ok_cnt", 32'(ok_cnt), 32'(m_ok));
    check("t5b_err_cnt", 32'(err_cnt), 32'(m_err));

    // downstream stall mid-drain
    send_pkt(4, 1'b0);
    start = nbytes;
    k = 0;
    while (nbytes == start && k < 200) begin
      cycle();
      k++;
    end
    check("stall_first_byte", 32'(nbytes != start), 1);
    stall_left = 5;
    run_idle("t6");
    check("t6_ok_cnt", 32'(ok_cnt), 32'(m_ok));

    // reset in the middle of a payload
    push(12'h0A5); push(12'h006); push(12'h001); push(12'h002); push(12'h003);
    wait_delivered();
    cycle();
    rst = 1'b1;
    m_active = 1'b0;
    m_ok = 0;
    m_err = 0;
    exp_q.delete();
    prev_stall = 1'b0;
    cycle();
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_pkt_ok", 32'(pkt_ok), 0);
    check("mid_rst_pkt_err", 32'(pkt_err), 0);
    check("mid_rst_err_code", 32'(err_code), 0);
    check("mid_rst_ok_cnt", 32'(ok_cnt), 0);
    check("mid_rst_err_cnt", 32'(err_cnt), 0);
    rst = 1'b0;
    cycle();
    send_pkt(5, 1'b0);
    run_idle("t7");
    check("t7_ok_cnt", 32'(ok_cnt), 1);
    check("t7_err_cnt", 32'(err_cnt), 0);

    // random mix with FIFO gaps and random backpressure
    rand_ready = 1'b1;
    gap_max = 4;
    for (int p = 0; p < 40; p++) begin
      kind = $urandom_range(0, 9);
      len = $urandom_range(1, MAXL);
      case (kind)
        5: send_pkt(len, 1'b1);
        6: begin
          push({4'h0, SOF});
          push({4'h0, ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255))});
        end
        7: begin
          push({4'h0, SOF});
          push({4'h0, 8'(len)});
          k = $urandom_range(0, len);
          for (int i = 0; i < k; i++) push({4'h0, 8'($urandom_range(0, 255))});
          push({4'($urandom_range(1, 15)), 8'($urandom_range(0, 255))});
        end
        8: begin
          for (int i = 0; i < 3; i++) begin
            w = 12'($urandom_range(0, 4095));
            if (w[7:0] == SOF && w[11:8] == 4'h0) w[8] = 1'b1;
            push(w);
          end
        end
        9: send_pkt(MAXL, 1'b0);
        default: send_pkt(len, 1'b0);
      endcase
    end
    run_idle("rand");
    check("rand_ok_cnt", 32'(ok_cnt), 32'(m_ok));
    check("rand_err_cnt", 32'(err_cnt), 32'(m_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_pkt_parser.md
Name: uart_rx_pkt_parser

Overview:
- Sits directly downstream of the UART receive FIFO and pops 12-bit words {BE,OE,PE,FE,data[7:0]} through the FIFO's rd_en/empty interface.
- Frames the byte stream into packets of the form SOF, LEN, payload[LEN], CHK, where CHK = XOR of LEN and all payload bytes.
- Buffers each payload and releases it on a valid/ready byte stream only after the checksum passes.
- Reports per-packet status pulses and keeps saturating good/bad packet counters.

Parameters:
- SOF_BYTE, 8'hA5, start-of-frame marker.
- MAX_LEN, 16, maximum payload length; LEN=0 or LEN>MAX_LEN is illegal.
- TIMEOUT_CYC, 1000, maximum UART_clk cycles between bytes inside a packet.

Ports:
- UART_clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- fifo_rd_data  in  12  FIFO output word {BE,OE,PE,FE,data}.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO pop request.
- out_data  out  8  payload byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the byte.
- out_last  out  1  marks the final payload byte of a packet.
- pkt_ok  out  1  one-cycle pulse: packet passed checksum.
- pkt_err  out  1  one-cycle pulse: packet aborted.
- err_code  out  3  error cause, held until the next pkt_err.
- ok_cnt  out  16  count of good packets, saturating.
- err_cnt  out  16  count of aborted packets, saturating.

Behaviour:
- Reset: all outputs 0, FSM in HUNT, rd_pending=0, timeout counter=0. rst dominates every other event, including mid-packet and mid-drain; a partial packet is discarded with no pulse.
- FIFO read timing:
  - fifo_rd_en = !fifo_empty && !rd_pending && state!=DRAIN && !pkt_ok && !pkt_err.
  - fifo_rd_data is valid on the cycle after fifo_rd_en; rd_pending is set for that cycle.
  - At most one read is outstanding at a time, so peak throughput is one byte per 2 cycles.
- Line error: a word whose flags [11:8] are non-zero.
  - In HUNT it is dropped silently.
  - In any other state it aborts with err_code=2 (LINE).
- FSM states: HUNT, LEN, PAYLOAD, CHK, DRAIN.
  - HUNT: a byte equal to SOF_BYTE goes to LEN; any other byte is dropped.
  - LEN: 1<=byte<=MAX_LEN stores len, sets chk_acc=byte, idx=0, and goes to PAYLOAD. Otherwise abort with err_code=1 (BAD_LEN). An SOF value here is treated as a LEN value.
  - PAYLOAD: write the byte to buf[idx], chk_acc^=byte, idx++. When idx reaches len-1, go to CHK. SOF_BYTE inside the payload is ordinary data.
  - CHK: byte==chk_acc pulses pkt_ok the next cycle, increments ok_cnt and goes to DRAIN with rd_idx=0. Mismatch aborts with err_code=3 (CHK).
  - DRAIN: out_valid=1, out_data=buf[rd_idx], out_last=(rd_idx==len-1). A byte completes on out_valid&&out_ready; after the last one, go to HUNT. out_data/out_last stay stable while out_valid&&!out_ready.
- Timeout:
  - Counter clears on each received word and on entry to HUNT; it counts in LEN/PAYLOAD/CHK while no word arrives.
  - Reaching TIMEOUT_CYC aborts with err_code=4 (TIMEOUT).
  - A word arriving in the same cycle as expiry wins: it is processed and the counter clears.
- Abort:
  - pkt_err pulses one cycle, err_code is updated, err_cnt increments, FSM goes to HUNT.
  - The buffer is not emitted.
  - The aborting byte is consumed and not re-examined as SOF.
- Counters saturate at 16'hFFFF.
- Latency: pkt_ok fires 1 cycle after the CHK byte is registered; the first out_valid comes 1 cycle after pkt_ok.

Decomposition:
- uart_pkt_pkg holds the FSM state enum, err_code constants (NONE=0, BAD_LEN=1, LINE=2, CHK=3, TIMEOUT=4) and the flag-field bit positions.
- One sub-module, uart_pkt_buf: MAX_LEN x 8 register file with one write port and a combinational read port.

Test Plan:
- Words A5,02,11,22,31 (flags 0), out_ready=1 -> pkt_ok, then out_data 11,22 with out_last on 22; ok_cnt=1.
- A5,02,11,22,30 -> pkt_err, err_code=3, no out_valid, err_cnt=1; then a valid packet follows and passes.
- A5,00 and A5,11 (MAX_LEN=16) -> two pkt_err, err_code=1, err_cnt=2.
- A5,01 then a word with PE set (0x244) -> pkt_err, err_code=2. A flagged word in HUNT -> no pulse.
- A5,03,AA then the FIFO stays empty for TIMEOUT_CYC cycles -> pkt_err, err_code=4. Repeat with a byte arriving on the expiry cycle -> no error.
- Good packet with out_ready low for 5 cycles mid-drain -> data held stable and fifo_rd_en=0 throughout; rst asserted mid-PAYLOAD -> outputs 0, next packet parses normally.
